req_encoder_serial: RTL

//  Parametrised successor to the 8-to-3 one-hot encoder. Accepts an N-bit request vector
//  (any number of bits set) and emits the binary index of every set bit, one per beat, in

---
 rtl/req_encoder_serial_pkg.sv | 13 +
 rtl/req_encoder_serial_prio_enc.sv | 32 +++
 rtl/req_encoder_serial.sv | 105 ++++++++++
 3 files changed

// File: rtl/req_encoder_serial_pkg.sv
// Shared types and constants for the serial request encoder.
// Scan state encoding and priority-order selectors.
package enc_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam int MODE_LSB_FIRST = 0;
   localparam int MODE_MSB_FIRST = 1;

endpackage

// File: rtl/req_encoder_serial_prio_enc.sv
// Combinational find-first-set over an N-bit vector.
// Reports the lowest or highest set bit depending on MODE; an empty vector yields idx 0.
module prio_enc
   import enc_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = MODE_LSB_FIRST,
   localparam int W   = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         found
);

   // Scan order is chosen so that the last matching bit visited is the winner.
   always_comb begin
      idx   = {W{1'b0}};
      found = 1'b0;
      if (MODE == MODE_MSB_FIRST) begin
         for (int i = 0; i < N; i++) begin
            idx   = vec[i] ? W'(i) : idx;
            found = found | vec[i];
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            idx   = vec[i] ? W'(i) : idx;
            found = found | vec[i];
         end
      end
   end

endmodule

// File: rtl/req_encoder_serial.sv
// Serialising request encoder: latches an N-bit request vector and streams the index
// of every set bit, one per valid/ready beat, flagging all-zero and multi-hot vectors.
module req_encoder_serial
   import enc_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = MODE_LSB_FIRST,
   localparam int W   = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         out_zero,
   output logic         out_multi
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   state_e         state_r, state_nxt_s;
   logic [N-1:0]   pend_r, pend_nxt_s;
   logic           zero_r, zero_nxt_s;
   logic           multi_r, multi_nxt_s;
   logic [W-1:0]   idx_s;
   logic           found_s;
   logic           scan_s;
   logic           last_s;
   logic           accept_s;
   logic [N-1:0]   mask_s;

   prio_enc #(.N(N), .MODE(MODE)) u_prio (
      .vec   (pend_r),
      .idx   (idx_s),
      .found (found_s)
   );

   // x & (x-1) drops the lowest set bit, so it is zero exactly when at most one bit is set.
   assign scan_s   = (state_r == SCAN);
   assign last_s   = ~|(pend_r & (pend_r - ONE));
   assign accept_s = in_valid & in_ready;
   assign mask_s   = found_s ? (ONE << idx_s) : {N{1'b0}};

   assign in_ready  = rst_n & en & (state_r == IDLE);
   assign out_valid = scan_s;
   assign out_idx   = idx_s;
   assign out_last  = scan_s & last_s;
   assign out_zero  = scan_s & zero_r;
   assign out_multi = scan_s & multi_r;

   // Next-state: latch on acceptance, retire one bit per output handshake.
   always_comb begin
      state_nxt_s = state_r;
      pend_nxt_s  = pend_r;
      zero_nxt_s  = zero_r;
      multi_nxt_s = multi_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = SCAN;
               pend_nxt_s  = in_vec;
               zero_nxt_s  = ~|in_vec;
               multi_nxt_s = |(in_vec & (in_vec - ONE));
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SCAN: begin
            if (out_ready) begin
               pend_nxt_s  = pend_r & ~mask_s;
               state_nxt_s = last_s ? IDLE : SCAN;
            end else begin
               state_nxt_s = SCAN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            pend_nxt_s  = {N{1'b0}};
            zero_nxt_s  = 1'b0;
            multi_nxt_s = 1'b0;
         end
      endcase
   end

   // State, pending-bit and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         pend_r  <= {N{1'b0}};
         zero_r  <= 1'b0;
         multi_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pend_r  <= pend_nxt_s;
         zero_r  <= zero_nxt_s;
         multi_r <= multi_nxt_s;
      end
   end

endmodule
